// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the L1 data-cache miss/store interface and the
// memory-side responder: RISC-V opcode and funct3 size constants, the
// responder state encoding, the captured-request record and the store
// legality rule shared by the responder and the store merge logic.
// No ports (package).
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    // Widths of the captured request record; the responder's default
    // ADDR_W/DATA_W match these.
    localparam int REQ_ADDR_W = 10;
    localparam int REQ_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic                  we;
        logic [2:0]            mask;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } dmem_req_t;

    // A store is legal only for byte, naturally aligned half, or aligned word.
    function automatic logic store_illegal(input logic [2:0] mask,
                                           input logic [1:0] addr_lo);
        case (mask)
            MASK_B:  return 1'b0;
            MASK_H:  return addr_lo[0];
            MASK_W:  return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Request/response channel between the L1 data cache (master) and the
// data-memory responder (slave). Both directions use valid/ready.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = read (line fill word)
//   req_mask            : funct3 access size (stores only)
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : full word (post-merge word for stores)
//   rsp_err             : misaligned store or illegal size, nothing written
// ---------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_mask;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/store_merge.sv
// ---------------------------------------------------------------------------
// store_merge
// Combinational merge of right-aligned store data into an existing 32-bit
// word. Byte and half stores replace only the addressed lanes; a word store
// replaces everything. Illegal (misaligned or unknown size) stores leave the
// word untouched and raise illegal.
//   old_word : current memory word
//   wdata    : right-aligned store data
//   mask     : funct3 access size
//   addr_lo  : byte offset within the word
//   merged   : resulting word
//   illegal  : store must not be committed
// ---------------------------------------------------------------------------
module store_merge
    import cache_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  mask,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged,
    output logic        illegal
);

    always_comb begin
        merged  = old_word;
        illegal = store_illegal(mask, addr_lo);
        if (!illegal) begin
            case (mask)
                MASK_B:  merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
                MASK_H:  merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                MASK_W:  merged = wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory end of the L1 data-cache miss/store interface. Accepts one request
// at a time, waits a fixed read or write latency, then presents a response
// that is held until the initiator takes it. Stores are merged into the
// addressed word and committed on the same edge the response is registered.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (memory contents are not reset)
//   bus   : request/response channel, slave side
//   busy  : a request is in flight (not IDLE)
// ---------------------------------------------------------------------------
module dmem_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W     = REQ_ADDR_W,
    parameter int DATA_W     = REQ_DATA_W,
    parameter int DEPTH      = 2 ** (ADDR_W - 2),
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic                busy
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    dmem_req_t         cap;
    logic [DATA_W-1:0] rdata;
    logic              err;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-3:0] idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic              merge_illegal;
    logic              req_illegal;
    logic              commit;

    assign idx      = cap.addr[ADDR_W-1:2];
    assign old_word = mem[idx];
    assign commit   = (state == S_WAIT) && (cnt == '0);

    // Legality is decided on the live request so an illegal store can go
    // straight to RESP without a latency wait. Reads are always legal.
    assign req_illegal = bus.req_we && store_illegal(bus.req_mask, bus.req_addr[1:0]);

    store_merge u_merge (
        .old_word (old_word),
        .wdata    (cap.wdata),
        .mask     (cap.mask),
        .addr_lo  (cap.addr[1:0]),
        .merged   (merged),
        .illegal  (merge_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            cap   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        cap <= '{we: bus.req_we, mask: bus.req_mask,
                                 addr: bus.req_addr, wdata: bus.req_wdata};
                        if (req_illegal) begin
                            state <= S_RESP;
                            err   <= 1'b1;
                            rdata <= '0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= bus.req_we ? CNT_W'(WR_LATENCY - 1)
                                                : CNT_W'(RD_LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= S_RESP;
                        rdata <= cap.we ? merged : old_word;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                        err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Store commit happens only on the WAIT->RESP edge, so a reset during
    // WAIT drops the store without touching memory.
    always_ff @(posedge clk) begin
        if (commit && cap.we && !merge_illegal) begin
            mem[idx] <= merged;
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    assign busy          = (state != S_IDLE);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory-side responder serving L1 data-cache traffic: line fills on load miss and write-through stores.
- Holds a word-organised backing store and accepts one request at a time over a valid/ready request channel.
- Applies a programmable access latency, then returns a response over a valid/ready response channel.
- Sits between the L1 cache subsystem, which is the initiator, and nothing further. It is the memory end of the miss/store interface.

Parameters:
- ADDR_W, 10, byte address width; the word index is addr[ADDR_W-1:2].
- DATA_W, 32, word width; fixed at 32.
- DEPTH, 256, number of 32-bit words, equal to 2**(ADDR_W-2).
- RD_LATENCY, 4, cycles from read accept to rsp_valid; must be >= 1.
- WR_LATENCY, 2, cycles from write accept to rsp_valid; must be >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request; high only in IDLE.
- req_we, input, 1: 1 = store, 0 = read (fill).
- req_mask, input, 3: access size, funct3 encoding: 000 byte, 001 half, 010 word. Ignored for reads.
- req_addr, input, ADDR_W: byte address.
- req_wdata, input, DATA_W: store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: initiator accepts the response.
- rsp_rdata, output, DATA_W: full word at the word index. For a store this is the post-merge word.
- rsp_err, output, 1: request was misaligned or had an illegal mask; no memory update.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0, captured request regs=0.
- Memory array is not reset; contents are undefined until written. The bench preloads it via a hierarchical write or an init file.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, capture we/mask/addr/wdata.
  - Legal request: go to WAIT with cnt = (we ? WR_LATENCY : RD_LATENCY) - 1.
  - Illegal request: go to RESP with rsp_err=1 and rsp_rdata=0.
- Legality rules:
  - Read: always legal; full word returned, and the cache does sub-word extraction.
  - Store byte: always legal.
  - Store half: illegal if addr[0]=1.
  - Store word: illegal if addr[1:0]!=0.
  - Any other mask on a store: illegal.
- WAIT:
  - req_ready=0.
  - cnt decrements each cycle while cnt!=0.
  - At the edge where cnt==0, go to RESP.
  - On that same edge, a read registers mem[idx] into rsp_rdata.
  - On that same edge, a store commits the merged word to mem[idx] and registers it into rsp_rdata.
- Latency: accept at edge E, rsp_valid high after edge E+LAT. With LAT=1 the response is visible one cycle after accept.
- Store merge:
  - Byte: lane addr[1:0] replaced by wdata[7:0].
  - Half: bits [15:0] or [31:16] replaced by wdata[15:0], selected by addr[1].
  - Word: whole word replaced.
  - All other lanes are preserved from mem[idx].
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake go to IDLE: rsp_valid=0, rsp_err=0 (rsp_rdata may hold).
  - No new request is accepted in the RESP cycle. Back-to-back requests are spaced by at least one IDLE cycle.
- req_valid while not IDLE is ignored. The initiator must hold the request until req_ready.
- Reset mid-WAIT: request dropped, no memory write. A store commits only on the WAIT→RESP edge.
- Reset mid-RESP: response dropped; the memory update has already happened.
- Request signals are sampled only at the accept edge. Later changes to req_* do not affect the in-flight access.

Decomposition:
- Shared package cache_pkg:
  - Opcode constants OP_LOAD=7'b0000011 and OP_STORE=7'b0100011.
  - Mask constants MASK_B=3'b000, MASK_H=3'b001, MASK_W=3'b010, MASK_BU=3'b100, MASK_HU=3'b101.
  - Responder state enum (IDLE, WAIT, RESP).
  - Request struct (we, mask, addr, wdata).
- Sub-module store_merge: combinational. Takes old word, wdata, mask and addr[1:0]; produces the merged word and an illegal flag. It is reusable by the L1 store path.

Test Plan:
- Read latency: preload mem[0x05]=0xDEADBEEF, RD_LATENCY=4. Read req_addr=0x014 accepted at edge E → rsp_valid rises after E+4, rsp_rdata=0xDEADBEEF, rsp_err=0, busy low after handshake.
- Byte store merge: mem[0x10]=0x11223344. Store byte addr=0x042, wdata=0x000000AB → rsp_rdata=0x11AB3344; a subsequent read of 0x040 returns 0x11AB3344.
- Half and word stores:
  - Store half addr=0x082, wdata=0x0000CAFE onto 0x00000000 → 0xCAFE0000.
  - Store word addr=0x0C0, wdata=0x12345678 → mem[0x30]=0x12345678.
- Misaligned store: store word addr=0x0C1 → response one cycle after accept with rsp_err=1 and rsp_rdata=0; mem[0x30] is unchanged on read-back.
- Response backpressure: hold rsp_ready=0 for 5 cycles during a read → rsp_valid and rsp_rdata stay stable and req_ready=0 throughout. Raising rsp_ready gives a handshake, IDLE next cycle, and a second request accepted.
- Reset mid-WAIT: store 0xFFFFFFFF to addr 0x000 (old mem[0]=0x0), assert reset one cycle after accept → rsp_valid never rises, outputs return to reset values immediately (async), and a later read of 0x000 returns 0x00000000.
